// File: rtl/data_sync_mc_pkg.sv
// Shared constants for the multi-channel bus synchroniser.
package sync_pkg;

  localparam int SYNC_MODE_LEVEL  = 0;
  localparam int SYNC_MODE_TOGGLE = 1;
  localparam int SYNC_MIN_STAGES  = 2;

endpackage

// File: rtl/data_sync_mc_ch.sv
// One synchroniser channel: qualifier chain, event detect, capture register,
// valid/ready hold and sticky overrun flag.
module data_sync_ch
  import sync_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_STAGES  = 2,
  parameter int TOGGLE_MODE = SYNC_MODE_LEVEL
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  input  logic                  ovr_clr_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  pulse_o,
  output logic                  overrun_o
);

  if (NUM_STAGES < SYNC_MIN_STAGES) begin : g_stage_check
    $error("data_sync_ch: NUM_STAGES must be at least SYNC_MIN_STAGES");
  end

  logic [NUM_STAGES-1:0] sync_q;
  logic                  hist_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  pulse_q;
  logic                  ovr_q, ovr_d;
  logic                  s_last;
  logic                  event_d;

  always_comb begin
    s_last  = sync_q[NUM_STAGES-1];
    event_d = (TOGGLE_MODE == SYNC_MODE_TOGGLE) ? (s_last ^ hist_q) : (s_last & ~hist_q);
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (event_d) begin
      data_d  = data_i;
      valid_d = 1'b1;
      // Overwriting an unaccepted word is the only way to raise overrun; it beats a clear.
      if (valid_q && !ready_i) ovr_d = 1'b1;
      else if (ovr_clr_i)      ovr_d = 1'b0;
    end else begin
      if (valid_q && ready_i) valid_d = 1'b0;
      if (ovr_clr_i)          ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[NUM_STAGES-2:0], enable_i};
      hist_q  <= s_last;
      data_q  <= data_d;
      valid_q <= valid_d;
      pulse_q <= event_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign pulse_o   = pulse_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel bus synchroniser on the destination clock; channels are fully
// independent instances of data_sync_ch over slices of the packed buses.
module data_sync_mc
  import sync_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CH      = 2,
  parameter int NUM_STAGES  = 2,
  parameter int TOGGLE_MODE = SYNC_MODE_LEVEL
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH*DATA_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]            bus_enable,
  input  logic [NUM_CH-1:0]            sync_ready,
  input  logic [NUM_CH-1:0]            overrun_clr,
  output logic [NUM_CH*DATA_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]            sync_valid,
  output logic [NUM_CH-1:0]            enable_pulse,
  output logic [NUM_CH-1:0]            overrun
);

  if (NUM_CH < 1) begin : g_ch_check
    $error("data_sync_mc: NUM_CH must be at least 1");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    data_sync_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_STAGES (NUM_STAGES),
      .TOGGLE_MODE(TOGGLE_MODE)
    ) u_ch (
      .clk_i    (CLK),
      .rst_i    (RST),
      .enable_i (bus_enable[c]),
      .data_i   (unsync_bus[c*DATA_WIDTH +: DATA_WIDTH]),
      .ready_i  (sync_ready[c]),
      .ovr_clr_i(overrun_clr[c]),
      .data_o   (sync_bus[c*DATA_WIDTH +: DATA_WIDTH]),
      .valid_o  (sync_valid[c]),
      .pulse_o  (enable_pulse[c]),
      .overrun_o(overrun[c])
    );
  end

endmodule

// File: tb/tb_data_sync_mc.sv
// Randomised + directed bench: a level-mode/2-stage and a toggle-mode/3-stage
// instance share stimulus and are checked against a sample-history model.
module tb_data_sync_mc;

  localparam int DW = 8;
  localparam int NC = 4;

  logic CLK = 1'b0;
  logic RST;
  logic [NC*DW-1:0] unsync_bus;
  logic [NC-1:0]    bus_enable, sync_ready, overrun_clr;
  logic [NC*DW-1:0] bus_l, bus_t;
  logic [NC-1:0]    val_l, val_t, pls_l, pls_t, ovr_l, ovr_t;

  always #5 CLK = ~CLK;

  data_sync_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .NUM_STAGES(2), .TOGGLE_MODE(0)) dut_l (
    .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .sync_ready(sync_ready), .overrun_clr(overrun_clr), .sync_bus(bus_l),
    .sync_valid(val_l), .enable_pulse(pls_l), .overrun(ovr_l));

  data_sync_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .NUM_STAGES(3), .TOGGLE_MODE(1)) dut_t (
    .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .sync_ready(sync_ready), .overrun_clr(overrun_clr), .sync_bus(bus_t),
    .sync_valid(val_t), .enable_pulse(pls_t), .overrun(ovr_t));

  int n_vec = 0;
  int n_err = 0;

  // Model: enable sampled at every edge; pulse at edge t derives from the samples
  // taken NUM_STAGES and NUM_STAGES+1 edges earlier. Samples before reset read 0.
  logic [NC-1:0] samp [0:8191];
  int            t = 0;
  int            floor_t = 1;
  int            stg  [2] = '{2, 3};
  int            mode [2] = '{0, 1};
  logic [DW-1:0] m_bus [2][NC];
  logic [NC-1:0] m_val [2];
  logic [NC-1:0] m_pls [2];
  logic [NC-1:0] m_ovr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic get_samp(input int i, input int c);
    if (i < floor_t) return 1'b0;
    return samp[i][c];
  endfunction

  function automatic logic [NC*DW-1:0] pack_bus(input int d);
    logic [NC*DW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*DW +: DW] = m_bus[d][c];
    return v;
  endfunction

  task automatic model_zero();
    for (int d = 0; d < 2; d++) begin
      m_val[d] = '0; m_pls[d] = '0; m_ovr[d] = '0;
      for (int c = 0; c < NC; c++) m_bus[d][c] = '0;
    end
  endtask

  task automatic model_edge();
    logic a, b, ev;
    t++;
    samp[t] = bus_enable;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        a  = get_samp(t - stg[d], c);
        b  = get_samp(t - stg[d] - 1, c);
        ev = (mode[d] == 1) ? (a != b) : (a && !b);
        m_pls[d][c] = ev;
        if (ev) begin
          if (m_val[d][c] && !sync_ready[c]) m_ovr[d][c] = 1'b1;
          else if (overrun_clr[c])           m_ovr[d][c] = 1'b0;
          m_val[d][c] = 1'b1;
          m_bus[d][c] = unsync_bus[c*DW +: DW];
        end else begin
          if (m_val[d][c] && sync_ready[c]) m_val[d][c] = 1'b0;
          if (overrun_clr[c])               m_ovr[d][c] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("lvl.sync_bus",     32'(bus_l), 32'(pack_bus(0)));
    chk("lvl.sync_valid",   32'(val_l), 32'(m_val[0]));
    chk("lvl.enable_pulse", 32'(pls_l), 32'(m_pls[0]));
    chk("lvl.overrun",      32'(ovr_l), 32'(m_ovr[0]));
    chk("tgl.sync_bus",     32'(bus_t), 32'(pack_bus(1)));
    chk("tgl.sync_valid",   32'(val_t), 32'(m_val[1]));
    chk("tgl.enable_pulse", 32'(pls_t), 32'(m_pls[1]));
    chk("tgl.overrun",      32'(ovr_t), 32'(m_ovr[1]));
  endtask

  // Called during the low phase; returns at the following negedge.
  task automatic step(input logic [NC-1:0] en, input logic [NC*DW-1:0] data,
                      input logic [NC-1:0] rdy, input logic [NC-1:0] clr);
    bus_enable  = en;
    unsync_bus  = data;
    sync_ready  = rdy;
    overrun_clr = clr;
    model_edge();
    @(posedge CLK);
    #1;
    compare_all();
    @(negedge CLK);
  endtask

  // Asserted mid low-phase with no edge in between, so a zero check proves asynchronous reset.
  task automatic do_reset(input logic [NC-1:0] en_at_release);
    #1;
    RST = 1'b1;
    #1;
    model_zero();
    compare_all();
    @(negedge CLK);
    @(negedge CLK);
    bus_enable = en_at_release;
    RST = 1'b0;
    floor_t = t + 1;
  endtask

  logic [NC-1:0]    en_r;
  logic [NC*DW-1:0] data_r;

  initial begin
    RST = 1'b1;
    bus_enable = '0; unsync_bus = '0; sync_ready = '0; overrun_clr = '0;
    model_zero();
    @(negedge CLK);
    do_reset('0);

    // Latency and single pulse with enable held high; then accept.
    repeat (3) step('0, 32'h0000_00A5, '0, '0);
    repeat (20) step(4'b0001, 32'h0000_00A5, '0, '0);
    step(4'b0001, 32'h0000_00A5, 4'b0001, '0);
    repeat (3) step(4'b0000, 32'h0000_00A5, '0, '0);

    // Overrun on ch0: two events unaccepted, third event with clear, then clear alone.
    repeat (4) step(4'b0001, 32'h0000_0033, '0, '0);
    repeat (4) step(4'b0000, 32'h0000_0033, '0, '0);
    repeat (4) step(4'b0001, 32'h0000_0044, '0, '0);
    repeat (4) step(4'b0000, 32'h0000_0044, '0, '0);
    step(4'b0001, 32'h0000_0066, '0, 4'b0001);
    step(4'b0001, 32'h0000_0066, '0, 4'b0001);
    step(4'b0001, 32'h0000_0066, '0, 4'b0001);
    repeat (3) step(4'b0001, 32'h0000_0066, '0, 4'b0001);
    repeat (4) step(4'b0000, 32'h0000_0066, '0, '0);

    // Accept and event in the same cycle.
    repeat (6) step(4'b0001, 32'h0000_0055, 4'b0001, '0);
    repeat (4) step(4'b0000, 32'h0000_0055, '0, '0);

    // Simultaneous events on channels 1 and 3 only.
    repeat (6) step(4'b1010, 32'hF000_0F00, '0, '0);
    repeat (4) step(4'b0000, 32'hF000_0F00, 4'b1111, 4'b1111);

    // Reset while channel 2 is mid-chain; drop it before release.
    step(4'b0100, 32'h00CC_0000, '0, '0);
    do_reset('0);
    repeat (6) step(4'b0000, 32'h00CC_0000, '0, '0);

    // Enable already high across reset release must yield an event in level mode.
    step(4'b0100, 32'h00DD_0000, '0, '0);
    do_reset(4'b0100);
    repeat (6) step(4'b0100, 32'h00DD_0000, '0, '0);

    // Randomised traffic with occasional resets.
    en_r = bus_enable;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 4) == 0) en_r[c] = ~en_r[c];
      data_r = $urandom;
      if ($urandom_range(0, 249) == 0) begin
        do_reset(en_r);
      end else begin
        step(en_r, data_r, 4'($urandom), ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_sync_mc.md
Name: data_sync_mc

Overview:
Multi-channel, parametrised bus synchroniser on the destination clock domain. Each channel carries a qualifier (`bus_enable`) through an N-stage flop chain and detects an event on it. On the event it captures that channel's unsynchronised bus into an output register. The captured word is held under a valid/ready handshake, and a sticky flag reports overrun. It is the general replacement for the single-channel, fixed-2-stage, level-only synchroniser used in the multi-clock system.

Parameters:
- DATA_WIDTH, 8, bits per channel bus
- NUM_CH, 2, number of independent channels (>=1)
- NUM_STAGES, 2, synchroniser flops on `bus_enable` (>=2)
- TOGGLE_MODE, 0, 0 = event is a rising edge of `bus_enable`; 1 = event is any transition of `bus_enable`

Ports:
- CLK  in  1  destination clock
- RST  in  1  asynchronous, active-high reset
- unsync_bus  in  NUM_CH*DATA_WIDTH  source-domain data, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]; must be stable while that channel's qualifier is propagating
- bus_enable  in  NUM_CH  source-domain qualifier per channel
- sync_ready  in  NUM_CH  consumer accepts `sync_bus` for the channel
- overrun_clr  in  NUM_CH  clears the channel's overrun flag
- sync_bus  out  NUM_CH*DATA_WIDTH  captured data, same packing as `unsync_bus`
- sync_valid  out  NUM_CH  captured data pending
- enable_pulse  out  NUM_CH  one-cycle event strobe, aligned with the capture
- overrun  out  NUM_CH  sticky: an event arrived while data was pending and not accepted

Behaviour:
- Single clock domain CLK. Reset is asynchronous and active-high (RST=1 resets immediately, no clock needed).
- Reset values, all outputs and internal flops = 0:
  - sync chain, edge-history flop
  - `sync_bus`, `sync_valid`, `enable_pulse`, `overrun`
- Per channel, independent; no cross-channel interaction:
  - Chain: `s[0] <= bus_enable`, `s[i] <= s[i-1]`; history flop `h <= s[NUM_STAGES-1]`.
  - Event: TOGGLE_MODE=0 → `s_last & ~h`; TOGGLE_MODE=1 → `s_last ^ h`.
- Latency: if `bus_enable` changes before CLK edge k (first sampled at k), then `enable_pulse` and the new `sync_bus` are registered at edge k+NUM_STAGES. `enable_pulse` is high for exactly one cycle per event.
- Capture: on event, `sync_bus <= unsync_bus` of that channel at the same edge; otherwise `sync_bus` holds its value.
- `sync_valid`, evaluated at each edge:
  - event → 1
  - else if `sync_valid & sync_ready` → 0
  - else hold
- `sync_ready` while `sync_valid`=0 has no effect.
- Event while `sync_valid`=1 and `sync_ready`=1 in the same cycle: the old word counts as accepted, the new word is loaded, `sync_valid` stays 1, no overrun.
- Event while `sync_valid`=1 and `sync_ready`=0: the new word overwrites (latest wins), `sync_valid` stays 1, `overrun <= 1`.
- `overrun`:
  - cleared by `overrun_clr` at the next edge
  - a set and a clear in the same cycle → set wins (flag = 1)
- TOGGLE_MODE=0, `bus_enable` held high: a single event only; a new event needs a low level to propagate through the chain first.
- Reset mid-propagation: the in-flight event is discarded. After RST deassertion, a `bus_enable` already high generates an event (level mode) once it traverses the chain.

Decomposition:
- Shared package `sync_pkg`:
  - mode constants `SYNC_MODE_LEVEL=0`, `SYNC_MODE_TOGGLE=1`
  - `SYNC_MIN_STAGES=2`, used for an elaboration-time parameter check
- Sub-module `data_sync_ch`:
  - one channel: chain, event detect, capture register, valid and overrun logic
  - parameters DATA_WIDTH, NUM_STAGES, TOGGLE_MODE
- Top: generate loop over NUM_CH plus bus slicing.

Test Plan:
- Reset/latency: DATA_WIDTH=8, NUM_STAGES=2, mode 0. Hold RST, then release; drive `unsync_bus[7:0]`=0xA5 and raise `bus_enable[0]` before edge 10 → `enable_pulse[0]`=1 only in the cycle after edge 12; `sync_bus[7:0]`=0xA5; `sync_valid[0]`=1 until `sync_ready[0]`=1, cleared at the following edge.
- Stage sweep: NUM_STAGES=4, same stimulus → pulse after edge 14. Holding `bus_enable` high for 20 cycles → exactly one pulse.
- Toggle mode: TOGGLE_MODE=1, `bus_enable` 0→1 with data 0x11, then 1→0 with data 0x22, 10 cycles apart, `sync_ready`=1 → two pulses; `sync_bus` shows 0x11 then 0x22; `overrun`=0.
- Overrun: `sync_ready`=0; events with data 0x33 then 0x44 → `sync_bus`=0x44, `sync_valid`=1, `overrun`=1. Assert `overrun_clr` in the same cycle as a third event → `overrun` stays 1. Clear alone → 0.
- Accept+event collision: `sync_valid`=1, `sync_ready`=1 on the event cycle, data 0x55 → `sync_valid` remains 1, `sync_bus`=0x55, `overrun`=0.
- Channel independence and reset: NUM_CH=4, events on channels 1 and 3 in the same cycle with data 0x0F/0xF0 → only those pulses and slices update. Assert RST mid-chain on channel 2 → no pulse after release, all outputs 0.
